// File: rtl/sun_sprite_motion_ctrl_if.sv
// rtl/sun_sprite_motion_ctrl_if.sv - video-slot write bus between motion controller and sprite core
interface sun_sprite_motion_ctrl_if;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/sun_sprite_motion_ctrl.sv
// rtl/sun_sprite_motion_ctrl.sv - bouncing sprite position update, written to the sprite core once per frame
// Bus outputs are registered from the next-cycle decode so every write is glitch-free and cleared by reset at once.
module sun_sprite_motion_ctrl #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int SPR_W = 64,
  parameter int SPR_H = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic                            enable,
  input  logic [3:0]                      dx_step,
  input  logic [3:0]                      dy_step,
  sun_sprite_motion_ctrl_if.master        bus,
  output logic [10:0]                     x_pos,
  output logic [10:0]                     y_pos,
  output logic                            busy
);

  localparam logic [11:0] X_LIM = 12'(H_MAX - SPR_W);
  localparam logic [11:0] Y_LIM = 12'(V_MAX - SPR_H);

  typedef enum logic [2:0] {INIT, IDLE, CALC, WR_X, WR_Y, WR_C} state_t;

  state_t      state, state_nxt;
  logic [11:0] x_r, y_r, x_nxt, y_nxt;
  logic        left_r, up_r, left_nxt, up_nxt;
  logic        bx, by, bounce;
  logic [1:0]  colour;
  logic        cs_r, cs_nxt;
  logic [13:0] addr_r, addr_nxt;
  logic [31:0] data_r, data_nxt;
  logic [11:0] dx, dy;

  assign dx = {8'd0, dx_step};
  assign dy = {8'd0, dy_step};

  // A zero step never touches its axis, so a sprite parked on an edge does not bounce.
  always_comb begin
    x_nxt    = x_r;
    left_nxt = left_r;
    bx       = 1'b0;
    if (dx_step != 4'd0) begin
      if (!left_r) begin
        if (x_r + dx >= X_LIM) begin
          x_nxt = X_LIM; left_nxt = 1'b1; bx = 1'b1;
        end else begin
          x_nxt = x_r + dx;
        end
      end else if (x_r <= dx) begin
        x_nxt = 12'd0; left_nxt = 1'b0; bx = 1'b1;
      end else begin
        x_nxt = x_r - dx;
      end
    end
  end

  always_comb begin
    y_nxt  = y_r;
    up_nxt = up_r;
    by     = 1'b0;
    if (dy_step != 4'd0) begin
      if (!up_r) begin
        if (y_r + dy >= Y_LIM) begin
          y_nxt = Y_LIM; up_nxt = 1'b1; by = 1'b1;
        end else begin
          y_nxt = y_r + dy;
        end
      end else if (y_r <= dy) begin
        y_nxt = 12'd0; up_nxt = 1'b0; by = 1'b1;
      end else begin
        y_nxt = y_r - dy;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cs_nxt    = 1'b0;
    addr_nxt  = 14'd0;
    data_nxt  = 32'd0;
    case (state)
      INIT: begin
        cs_nxt    = 1'b1;
        addr_nxt  = 14'h2000;
        state_nxt = IDLE;
      end
      IDLE: if (frame_start && enable) state_nxt = CALC;
      CALC: begin
        cs_nxt    = 1'b1;
        addr_nxt  = 14'h2001;
        data_nxt  = {21'd0, x_nxt[10:0]};
        state_nxt = WR_X;
      end
      WR_X: begin
        cs_nxt    = 1'b1;
        addr_nxt  = 14'h2002;
        data_nxt  = {21'd0, y_r[10:0]};
        state_nxt = WR_Y;
      end
      WR_Y: begin
        if (bounce) begin
          cs_nxt    = 1'b1;
          addr_nxt  = 14'h2003;
          data_nxt  = {30'd0, colour};
          state_nxt = WR_C;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_C:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      x_r    <= 12'd0;
      y_r    <= 12'd0;
      left_r <= 1'b0;
      up_r   <= 1'b0;
      colour <= 2'd0;
      bounce <= 1'b0;
      cs_r   <= 1'b0;
      addr_r <= 14'd0;
      data_r <= 32'd0;
    end else begin
      state  <= state_nxt;
      cs_r   <= cs_nxt;
      addr_r <= addr_nxt;
      data_r <= data_nxt;
      if (state == CALC) begin
        x_r    <= x_nxt;
        y_r    <= y_nxt;
        left_r <= left_nxt;
        up_r   <= up_nxt;
        bounce <= bx | by;
        if (bx | by) colour <= colour + 2'd1;
      end
    end
  end

  assign bus.cs      = cs_r;
  assign bus.write   = cs_r;
  assign bus.addr    = addr_r;
  assign bus.wr_data = data_r;
  assign x_pos       = x_r[10:0];
  assign y_pos       = y_r[10:0];
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sun_sprite_motion_ctrl.sv
// tb/tb_sun_sprite_motion_ctrl.sv - scoreboard bench for sun_sprite_motion_ctrl
module tb_sun_sprite_motion_ctrl;
  localparam int X_LIM = 640 - 64;
  localparam int Y_LIM = 480 - 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] dx_step = 4'd0;
  logic [3:0] dy_step = 4'd0;
  logic [10:0] x_pos, y_pos;
  logic        busy;

  sun_sprite_motion_ctrl_if vbus ();

  sun_sprite_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .enable(enable),
    .dx_step(dx_step), .dy_step(dy_step), .bus(vbus.master),
    .x_pos(x_pos), .y_pos(y_pos), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int data; int x; int y;} exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int ctrl_writes = 0;
  int free_cyc = 0;
  int mx = 0, my = 0, mcol = 0;
  bit mleft = 0, mup = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: signed target position, clamped to the frame edges; a clamp reverses direction.
  task automatic step_axis(inout int p, inout bit back, input int s, input int lim, output bit b);
    int t;
    b = 0;
    if (s == 0) return;
    t = back ? p - s : p + s;
    if (t >= lim)     begin p = lim; back = 1; b = 1; end
    else if (t <= 0)  begin p = 0;   back = 0; b = 1; end
    else              p = t;
  endtask

  task automatic model_frame(input int n, input int sx, input int sy);
    bit bx, by;
    step_axis(mx, mleft, sx, X_LIM, bx);
    step_axis(my, mup, sy, Y_LIM, by);
    sb.push_back('{n + 2, 'h2001, mx, mx, my});
    sb.push_back('{n + 3, 'h2002, my, mx, my});
    if (bx || by) begin
      mcol = (mcol + 1) % 4;
      sb.push_back('{n + 4, 'h2003, mcol, mx, my});
    end
    free_cyc = n + 4 + ((bx || by) ? 1 : 0);
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle;
    while (cyc < free_cyc) next_cycle();
  endtask

  task automatic pulse(input bit en, input int sx, input int sy, output int n);
    next_cycle();
    n = cyc;
    if (n >= free_cyc) begin
      dx_step = 4'(sx);
      dy_step = 4'(sy);
    end
    frame_start = 1'b1;
    enable = en;
    if (en && n >= free_cyc) model_frame(n, int'(dx_step), int'(dy_step));
    next_cycle();
    frame_start = 1'b0;
  endtask

  // Monitor: every write on the bus must match the head of the scoreboard, in content and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_cs", int'(vbus.cs), 0);
      check("reset_addr", int'(vbus.addr), 0);
      check("reset_busy", int'(busy), 1);
      check("reset_x", int'(x_pos), 0);
    end else if (vbus.cs) begin
      if (vbus.addr == 14'h2003) ctrl_writes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0d with nothing expected (cycle %0d)",
                 vbus.addr, vbus.wr_data, cyc);
      end else begin
        e = sb.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", int'(vbus.addr), e.addr);
        check("wr_data", int'(vbus.wr_data), e.data);
        check("wr_write", int'(vbus.write), 1);
        check("x_pos", int'(x_pos), e.x);
        check("y_pos", int'(y_pos), e.y);
      end
    end else begin
      check("idle_bus", int'({vbus.write, vbus.addr, vbus.wr_data}), 0);
      if (sb.size() != 0) check("write_late", cyc <= sb[0].cyc ? 1 : 0, 1);
    end
  end

  initial begin
    int n, c0, k;
    repeat (3) @(posedge clk);
    #2;
    sb.push_back('{1, 'h2000, 0, 0, 0});
    free_cyc = 1;
    reset = 1'b0;
    while (cyc < 2) next_cycle();
    @(negedge clk);
    check("busy_after_init", int'(busy), 0);

    wait_idle();
    pulse(1, 3, 2, n);
    while (cyc < n + 3) next_cycle();
    @(negedge clk);
    check("busy_in_wr_y", int'(busy), 1);
    next_cycle();
    @(negedge clk);
    check("busy_low_n4", int'(busy), 0);
    check("pos_x_3", int'(x_pos), 3);
    check("pos_y_2", int'(y_pos), 2);

    pulse(0, 5, 5, n);
    wait_idle();
    pulse(1, 1, 1, n);
    pulse(1, 7, 7, n);
    wait_idle();
    repeat (3) next_cycle();
    check("ignored_pulse_x", int'(x_pos), 4);
    check("ignored_pulse_y", int'(y_pos), 3);

    while (575 - mx > 15) begin wait_idle(); pulse(1, 15, 0, n); end
    wait_idle();
    if (575 - mx > 0) pulse(1, 575 - mx, 0, n);
    wait_idle();
    check("x_at_575", mx, 575);
    pulse(1, 4, 0, n);
    wait_idle();
    check("x_clamp_576", int'(x_pos), 576);
    pulse(1, 4, 0, n);
    wait_idle();
    check("x_back_572", int'(x_pos), 572);

    while (mx - 2 > 15) begin wait_idle(); pulse(1, 15, 0, n); end
    wait_idle();
    if (mx - 2 > 0) pulse(1, mx - 2, 0, n);
    while (412 - my > 15) begin wait_idle(); pulse(1, 0, 15, n); end
    wait_idle();
    if (412 - my > 0) pulse(1, 0, 412 - my, n);
    wait_idle();
    check("x_parked_2", int'(x_pos), 2);
    c0 = ctrl_writes;
    pulse(1, 4, 4, n);
    wait_idle();
    repeat (2) next_cycle();
    check("corner_x", int'(x_pos), 0);
    check("corner_y", int'(y_pos), 416);
    check("corner_ctrl_writes", ctrl_writes - c0, 1);
    check("corner_colour", mcol, 2);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 5)) next_cycle();
      pulse($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), n);
    end

    wait_idle();
    pulse(1, 9, 9, n);
    while (cyc < n + 3) next_cycle();
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("abort_cs", int'(vbus.cs), 0);
    check("abort_data", int'(vbus.wr_data), 0);
    mx = 0; my = 0; mleft = 0; mup = 0; mcol = 0;
    repeat (2) next_cycle();
    sb.push_back('{1, 'h2000, 0, 0, 0});
    free_cyc = 1;
    reset = 1'b0;
    repeat (3) next_cycle();
    check("after_abort_x", int'(x_pos), 0);
    check("after_abort_y", int'(y_pos), 0);
    pulse(1, 2, 1, n);
    wait_idle();

    k = 0;
    while (sb.size() != 0 && k < 50) begin next_cycle(); k++; end
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
